// File: rtl/rc4_key_search.sv
// rc4_key_search: self-iterating RC4 brute-force engine. For each candidate key
// in [key_lo, key_hi] it fills S with the identity permutation, runs the key
// schedule, decrypts the message with the keystream and checks that every
// plaintext byte is a lowercase letter or a space.
// Ports:
//   CLOCK_50, reset_n (async, active low)
//   start, key_lo, key_hi       : search request and inclusive key range
//   busy, done, found, key_out  : search status and result
//   s_addr/s_wdata/s_wren/s_q   : S RAM (1-cycle read latency)
//   enc_addr/enc_q              : encrypted-message ROM (1-cycle read latency)
//   dec_addr/dec_data/dec_wren  : decrypted-message RAM
// Build option: define RC4_EARLY_ABORT_EN to end a candidate at its first
// invalid plaintext byte instead of decrypting the whole message.
module rc4_key_search #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned KEY_BITS  = 24,
  parameter int unsigned MSG_LEN   = 32
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [KEY_BITS-1:0]        key_lo,
  input  logic [KEY_BITS-1:0]        key_hi,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [KEY_BITS-1:0]        key_out,
  output logic [7:0]                 s_addr,
  output logic [7:0]                 s_wdata,
  output logic                       s_wren,
  input  logic [7:0]                 s_q,
  output logic [$clog2(MSG_LEN)-1:0] enc_addr,
  input  logic [7:0]                 enc_q,
  output logic [$clog2(MSG_LEN)-1:0] dec_addr,
  output logic [7:0]                 dec_data,
  output logic                       dec_wren
);

  localparam int unsigned AW  = $clog2(MSG_LEN);
  localparam int unsigned KW  = 8 * KEY_BYTES;
  localparam int unsigned KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_KSA, ST_PRGA, ST_NEXT, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          step_q, step_d;
  logic [7:0]          idx_q, idx_d;
  logic [7:0]          j_q, j_d;
  logic [7:0]          si_q, si_d;
  logic [7:0]          sj_q, sj_d;
  logic [KIW-1:0]      kidx_q, kidx_d;
  logic [AW-1:0]       k_q, k_d;
  logic                pass_q, pass_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [KEY_BITS-1:0] hi_q, hi_d;
  logic                busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [7:0]          s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic                s_wren_q, s_wren_d;
  logic [AW-1:0]       enc_addr_q, enc_addr_d, dec_addr_q, dec_addr_d;
  logic [7:0]          dec_data_q, dec_data_d;
  logic                dec_wren_q, dec_wren_d;

  logic [KW-1:0]       key_full_c;
  logic [7:0]          key_byte_c;
  logic [7:0]          dec_byte_c;
  logic                valid_c;
  logic                abort_c;

  // Key byte for the current KSA index; byte 0 is the most significant.
  always_comb begin
    key_full_c = KW'(key_q);
    key_byte_c = 8'h00;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (KIW'(b) == kidx_q) key_byte_c = key_full_c[KW-1-8*b -: 8];
    end
  end

  assign dec_byte_c = s_q ^ enc_q;
  assign valid_c    = ((dec_byte_c >= 8'h61) && (dec_byte_c <= 8'h7A)) ||
                      (dec_byte_c == 8'h20);

`ifdef RC4_EARLY_ABORT_EN
  assign abort_c = !pass_q;
`else
  assign abort_c = 1'b0;
`endif

  // Next-state and registered-output logic; step_q names the cycle now ending.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    idx_d      = idx_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    kidx_d     = kidx_q;
    k_d        = k_q;
    pass_d     = pass_q;
    key_d      = key_q;
    hi_d       = hi_q;
    busy_d     = busy_q;
    done_d     = done_q;
    found_d    = found_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wren_d   = 1'b0;
    enc_addr_d = enc_addr_q;
    dec_addr_d = dec_addr_q;
    dec_data_d = dec_data_q;
    dec_wren_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          key_d   = key_lo;
          hi_d    = key_hi;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          found_d = 1'b0;
          if (key_lo > key_hi) begin
            // Empty range: one pass through NEXT finishes without touching memory.
            state_d = ST_NEXT;
            pass_d  = 1'b0;
          end else begin
            state_d   = ST_INIT;
            idx_d     = 8'd0;
            s_addr_d  = 8'd0;
            s_wdata_d = 8'd0;
            s_wren_d  = 1'b1;
          end
        end
      end

      ST_INIT: begin
        if (idx_q == 8'hFF) begin
          state_d  = ST_KSA;
          step_d   = 4'd0;
          idx_d    = 8'd0;
          j_d      = 8'd0;
          kidx_d   = '0;
          pass_d   = 1'b1;
          s_addr_d = 8'd0;
        end else begin
          idx_d     = idx_q + 8'd1;
          s_addr_d  = idx_d;
          s_wdata_d = idx_d;
          s_wren_d  = 1'b1;
        end
      end

      ST_KSA: begin
        step_d = step_q + 4'd1;
        unique case (step_q)
          4'd1: begin
            si_d     = s_q;
            j_d      = j_q + s_q + key_byte_c;
            s_addr_d = j_d;
          end
          4'd3: begin
            sj_d      = s_q;
            s_addr_d  = idx_q;
            s_wdata_d = s_q;
            s_wren_d  = 1'b1;
          end
          4'd4: begin
            s_addr_d  = j_q;
            s_wdata_d = si_q;
            s_wren_d  = 1'b1;
          end
          4'd5: begin
            step_d = 4'd0;
            kidx_d = (kidx_q == KIW'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;
            if (idx_q == 8'hFF) begin
              // PRGA starts with i already advanced to 1.
              state_d  = ST_PRGA;
              idx_d    = 8'd1;
              j_d      = 8'd0;
              k_d      = '0;
              s_addr_d = 8'd1;
            end else begin
              idx_d    = idx_q + 8'd1;
              s_addr_d = idx_d;
            end
          end
          default: ;
        endcase
      end

      ST_PRGA: begin
        step_d = step_q + 4'd1;
        unique case (step_q)
          4'd1: begin
            si_d     = s_q;
            j_d      = j_q + s_q;
            s_addr_d = j_d;
          end
          4'd3: begin
            sj_d      = s_q;
            s_addr_d  = idx_q;
            s_wdata_d = s_q;
            s_wren_d  = 1'b1;
          end
          4'd4: begin
            s_addr_d  = j_q;
            s_wdata_d = si_q;
            s_wren_d  = 1'b1;
          end
          4'd5: begin
            // Swap is committed, so this read returns the post-swap S[si+sj].
            s_addr_d   = si_q + sj_q;
            enc_addr_d = k_q;
          end
          4'd7: begin
            dec_data_d = dec_byte_c;
            dec_addr_d = k_q;
            dec_wren_d = 1'b1;
            if (!valid_c) pass_d = 1'b0;
          end
          4'd8: begin
            step_d = 4'd0;
            if ((k_q == AW'(MSG_LEN - 1)) || abort_c) begin
              state_d = ST_NEXT;
            end else begin
              k_d      = k_q + 1'b1;
              idx_d    = idx_q + 8'd1;
              s_addr_d = idx_d;
            end
          end
          default: ;
        endcase
      end

      ST_NEXT: begin
        if (pass_q || (key_q >= hi_q)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = pass_q;
        end else begin
          key_d     = key_q + 1'b1;
          state_d   = ST_INIT;
          idx_d     = 8'd0;
          s_addr_d  = 8'd0;
          s_wdata_d = 8'd0;
          s_wren_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      step_q     <= 4'd0;
      idx_q      <= 8'd0;
      j_q        <= 8'd0;
      si_q       <= 8'd0;
      sj_q       <= 8'd0;
      kidx_q     <= '0;
      k_q        <= '0;
      pass_q     <= 1'b0;
      key_q      <= '0;
      hi_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      s_addr_q   <= 8'd0;
      s_wdata_q  <= 8'd0;
      s_wren_q   <= 1'b0;
      enc_addr_q <= '0;
      dec_addr_q <= '0;
      dec_data_q <= 8'd0;
      dec_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      kidx_q     <= kidx_d;
      k_q        <= k_d;
      pass_q     <= pass_d;
      key_q      <= key_d;
      hi_q       <= hi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wren_q   <= s_wren_d;
      enc_addr_q <= enc_addr_d;
      dec_addr_q <= dec_addr_d;
      dec_data_q <= dec_data_d;
      dec_wren_q <= dec_wren_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;
  assign key_out  = key_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wren   = s_wren_q;
  assign enc_addr = enc_addr_q;
  assign dec_addr = dec_addr_q;
  assign dec_data = dec_data_q;
  assign dec_wren = dec_wren_q;

endmodule

// File: tb/tb_rc4_key_search.sv
// Testbench for rc4_key_search: memory models, a textbook RC4 reference used
// to build the ciphertext for key 0x000249, and directed search scenarios.
module tb_rc4_key_search;

  localparam int MSG  = 32;
  localparam int AW   = 5;
  localparam int CAND = 256 + 1536 + 9 * MSG + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [23:0]   key_lo = '0;
  logic [23:0]   key_hi = '0;
  logic          busy, done, found;
  logic [23:0]   key_out;
  logic [7:0]    s_addr, s_wdata, s_q;
  logic          s_wren;
  logic [AW-1:0] enc_addr, dec_addr;
  logic [7:0]    enc_q, dec_data;
  logic          dec_wren;

  logic [7:0]    s_mem   [256];
  logic [7:0]    enc_rom [MSG];
  logic [7:0]    dec_mem [MSG];
  logic [7:0]    ks_m    [MSG];
  logic [8*MSG-1:0] pt;

  int n_checks = 0;
  int n_errors = 0;
  int s_wr_cnt = 0;
  int dec_wr_cnt = 0;

  always #5 clk = ~clk;

  rc4_key_search #(.KEY_BYTES(3), .KEY_BITS(24), .MSG_LEN(MSG)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start),
    .key_lo(key_lo), .key_hi(key_hi),
    .busy(busy), .done(done), .found(found), .key_out(key_out),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_q(s_q),
    .enc_addr(enc_addr), .enc_q(enc_q),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren)
  );

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    if (s_wren) begin
      s_mem[s_addr] <= s_wdata;
      s_wr_cnt      <= s_wr_cnt + 1;
    end
    s_q   <= s_mem[s_addr];
    enc_q <= enc_rom[enc_addr];
    if (dec_wren) begin
      dec_mem[dec_addr] <= dec_data;
      dec_wr_cnt        <= dec_wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_valid(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Reference RC4 keystream for a 3-byte key, MSB byte first.
  task automatic rc4_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] i8, j, t, kb;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb = (n % 3 == 0) ? key[23:16] : (n % 3 == 1) ? key[15:8] : key[7:0];
      j = j + s[n] + kb;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i8 = 8'd0;
    j  = 8'd0;
    for (int k = 0; k < MSG; k++) begin
      i8 = i8 + 8'd1;
      j  = j + s[i8];
      t = s[i8]; s[i8] = s[j]; s[j] = t;
      t = s[i8] + s[j];
      ks_m[k] = s[t];
    end
  endtask

  // Cycles one candidate takes, and whether it decrypts to valid text.
  task automatic cand_cycles(input logic [23:0] key, output int cyc, output bit ok);
    int bad;
    bad = -1;
    rc4_model(key);
    for (int k = 0; k < MSG; k++)
      if (bad < 0 && !is_valid(enc_rom[k] ^ ks_m[k])) bad = k;
    ok = (bad < 0);
`ifdef RC4_EARLY_ABORT_EN
    cyc = ok ? CAND : 256 + 1536 + 9 * (bad + 1) + 1;
`else
    cyc = CAND;
`endif
  endtask

  // Expected start-to-done distance for a whole range.
  task automatic exp_search(input logic [23:0] lo, input logic [23:0] hi, output int cyc);
    int c;
    bit ok;
    cyc = 1;
    for (int k = int'(lo); k <= int'(hi); k++) begin
      cand_cycles(24'(k), c, ok);
      cyc += c;
      if (ok) break;
    end
  endtask

  task automatic pulse_start(input logic [23:0] lo, input logic [23:0] hi);
    @(negedge clk);
    start  = 1'b1;
    key_lo = lo;
    key_hi = hi;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Start a search and count negedges until done; optionally poke start mid-search.
  task automatic run_search(input logic [23:0] lo, input logic [23:0] hi,
                            input bit poke, output int cyc);
    pulse_start(lo, hi);
    cyc = 1;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("done_clear_after_start", 32'(done), 32'd0);
    while (!done && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3000) begin
        start  = 1'b1;
        key_lo = 24'h000000;
        key_hi = 24'hFFFFFF;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"},     32'(busy),     32'd0);
    check_eq({pfx, "_done"},     32'(done),     32'd0);
    check_eq({pfx, "_found"},    32'(found),    32'd0);
    check_eq({pfx, "_key_out"},  32'(key_out),  32'd0);
    check_eq({pfx, "_s_addr"},   32'(s_addr),   32'd0);
    check_eq({pfx, "_s_wdata"},  32'(s_wdata),  32'd0);
    check_eq({pfx, "_s_wren"},   32'(s_wren),   32'd0);
    check_eq({pfx, "_enc_addr"}, 32'(enc_addr), 32'd0);
    check_eq({pfx, "_dec_addr"}, 32'(dec_addr), 32'd0);
    check_eq({pfx, "_dec_data"}, 32'(dec_data), 32'd0);
    check_eq({pfx, "_dec_wren"}, 32'(dec_wren), 32'd0);
  endtask

  initial begin
    int cyc;
    int exp;
    int s_snap;
    int d_snap;
    int mism;

    pt = "the quick brown fox jumps over a";
    rc4_model(24'h000249);
    for (int k = 0; k < MSG; k++) enc_rom[k] = pt[8*(MSG-1-k) +: 8] ^ ks_m[k];

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Empty range: done two cycles after start, no memory traffic.
    s_snap = s_wr_cnt;
    d_snap = dec_wr_cnt;
    run_search(24'd5, 24'd4, 1'b0, cyc);
    check_eq("empty_cycles", 32'(cyc), 32'd2);
    check_eq("empty_found", 32'(found), 32'd0);
    check_eq("empty_key_out", 32'(key_out), 32'd5);
    check_eq("empty_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("empty_s_wren", 32'(s_wr_cnt - s_snap), 32'd0);
    check_eq("empty_dec_wren", 32'(dec_wr_cnt - d_snap), 32'd0);

    // Range without the key.
`ifdef RC4_EARLY_ABORT_EN
    exp_search(24'd0, 24'd3, exp);
`else
    exp = 4 * CAND + 1;
`endif
    run_search(24'd0, 24'd3, 1'b0, cyc);
    check_eq("miss_cycles", 32'(cyc), 32'(exp));
    check_eq("miss_found", 32'(found), 32'd0);
    check_eq("miss_key_out", 32'(key_out), 32'h000003);
    check_eq("miss_busy", 32'(busy), 32'd0);

    // Reset during the key schedule of the second candidate.
    pulse_start(24'h000240, 24'h00024F);
    repeat (CAND + 400) @(negedge clk);
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Known plaintext, with a stray start pulse while busy.
`ifdef RC4_EARLY_ABORT_EN
    exp_search(24'h000240, 24'h00024F, exp);
`else
    exp = 10 * CAND + 1;
`endif
    run_search(24'h000240, 24'h00024F, 1'b1, cyc);
    check_eq("hit_cycles", 32'(cyc), 32'(exp));
    check_eq("hit_found", 32'(found), 32'd1);
    check_eq("hit_key_out", 32'(key_out), 32'h000249);
    check_eq("hit_busy", 32'(busy), 32'd0);
    mism = 0;
    for (int k = 0; k < MSG; k++)
      if (dec_mem[k] !== pt[8*(MSG-1-k) +: 8]) mism++;
    check_eq("hit_dec_ram", 32'(mism), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("hit_key_stable", 32'(key_out), 32'h000249);
    check_eq("hit_done_held", 32'(done), 32'd1);

    // Restart from DONE with a single-key range.
    run_search(24'h000249, 24'h000249, 1'b0, cyc);
    check_eq("single_cycles", 32'(cyc), 32'(CAND + 1));
    check_eq("single_found", 32'(found), 32'd1);
    check_eq("single_key_out", 32'(key_out), 32'h000249);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
